// File: rtl/pool_pkg.sv
// rtl/pool_pkg.sv - shared FP16 pooling constants, state encoding and ordering helpers
package pool_pkg;

   localparam int DW       = 16;
   localparam int NUM_ELEM = 9;

   localparam logic [DW-1:0] FP16_QNAN = 16'h7E00;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CMP   = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } pool_state_t;

   // Maps sign-magnitude FP16 onto an unsigned total order: -inf lowest, -0 just below +0.
   function automatic logic [DW-1:0] fp16_key(input logic [DW-1:0] x);
      return x[DW-1] ? ~x : (x ^ 16'h8000);
   endfunction

   function automatic logic fp16_isnan(input logic [DW-1:0] x);
      return (x[14:10] == 5'h1F) && (x[9:0] != 10'd0);
   endfunction

endpackage

// File: rtl/fp16_max2.sv
// rtl/fp16_max2.sv - combinational two-input FP16 maximum with NaN detect
module fp16_max2
   import pool_pkg::*;
(
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   output logic [DW-1:0] max,
   output logic          any_nan
);

   // Strictly greater, so equal keys keep operand a (the running accumulator).
   assign max     = (fp16_key(b) > fp16_key(a)) ? b : a;
   assign any_nan = fp16_isnan(a) | fp16_isnan(b);

endmodule

// File: rtl/max_pool_3x3.sv
// rtl/max_pool_3x3.sv - reduces one captured 3x3 FP16 window to its maximum, one element per cycle
module max_pool_3x3
   import pool_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   pool_ready_3x3,
   input  logic [DW*NUM_ELEM-1:0] im_3x3,
   output logic                   pool_valid_3x3,
   input  logic                   out_full,
   output logic                   out_wr_en,
   output logic [DW-1:0]          out_data,
   output logic                   busy,
   output logic [CNT_W-1:0]       result_count
);

   pool_state_t            state_q;
   logic [DW*NUM_ELEM-1:0] buf_q;
   logic [DW-1:0]          acc_q;
   logic                   nan_q;
   logic [3:0]             idx_q;
   logic                   valid_q;
   logic                   wr_en_q;
   logic [DW-1:0]          data_q;
   logic                   busy_q;
   logic [CNT_W-1:0]       count_q;
   logic [CNT_W-1:0]       count_d;

   logic [DW-1:0] elems [NUM_ELEM];
   logic [DW-1:0] cur_elem;
   logic [DW-1:0] max_ab;
   logic          pair_nan;

   always_comb begin
      for (int k = 0; k < NUM_ELEM; k++) begin
         elems[k] = buf_q[(NUM_ELEM-1-k)*DW +: DW];
      end
   end

   assign cur_elem = elems[idx_q];
   assign count_d  = count_q + CNT_W'(1);

   fp16_max2 u_max2 (
      .a       (acc_q),
      .b       (cur_elem),
      .max     (max_ab),
      .any_nan (pair_nan)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         buf_q   <= '0;
         acc_q   <= '0;
         nan_q   <= 1'b0;
         idx_q   <= 4'd0;
         valid_q <= 1'b0;
         wr_en_q <= 1'b0;
         data_q  <= '0;
         busy_q  <= 1'b0;
         count_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               wr_en_q <= 1'b0;
               if (pool_ready_3x3) begin
                  buf_q   <= im_3x3;
                  acc_q   <= im_3x3[DW*NUM_ELEM-1 -: DW];
                  nan_q   <= fp16_isnan(im_3x3[DW*NUM_ELEM-1 -: DW]);
                  idx_q   <= 4'd1;
                  busy_q  <= 1'b1;
                  state_q <= CMP;
               end
            end
            CMP: begin
               acc_q <= max_ab;
               nan_q <= nan_q | pair_nan;
               idx_q <= idx_q + 4'd1;
               if (idx_q == 4'(NUM_ELEM-1)) begin
                  state_q <= WRITE;
               end
            end
            WRITE: begin
               if (!out_full) begin
                  wr_en_q <= 1'b1;
                  data_q  <= nan_q ? FP16_QNAN : acc_q;
                  count_q <= count_d;
                  valid_q <= 1'b1;
                  state_q <= DONE;
               end
            end
            DONE: begin
               wr_en_q <= 1'b0;
               // Only a low ready re-arms IDLE, so a level-held ready cannot start a second window.
               if (!pool_ready_3x3) begin
                  valid_q <= 1'b0;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign pool_valid_3x3 = valid_q;
   assign out_wr_en      = wr_en_q;
   assign out_data       = data_q;
   assign busy           = busy_q;
   assign result_count   = count_q;

endmodule

// File: doc/max_pool_3x3.md
Name: max_pool_3x3

Overview:
- Downstream consumer of the command/sequencing block's 3x3 pooling path (op_type 3, POOLING_3x3_MAX).
- Takes one 3x3 FP16 window (im_3x3) when pool_ready_3x3 is asserted and reduces its 9 elements to their maximum, one element per cycle.
- Pushes the result into the write-back output FIFO, then returns pool_valid_3x3 to the sequencer.

Parameters:
- DW, 16, element width (FP16).
- NUM_ELEM, 9, elements per window.
- CNT_W, 16, width of the result counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- pool_ready_3x3  in  1  level from sequencer; window on im_3x3 is stable while high.
- im_3x3  in  144  window; element k = im_3x3[143-16k -: 16], k=0..8 (element 0 = first loaded).
- pool_valid_3x3  out  1  result written; held until pool_ready_3x3 is sampled low.
- out_full  in  1  output FIFO full.
- out_wr_en  out  1  one-cycle FIFO write strobe.
- out_data  out  16  pooled FP16 result.
- busy  out  1  high in any state other than IDLE.
- result_count  out  CNT_W  number of results written since reset; wraps.

Behaviour:
- Reset (rst sampled high at posedge): state IDLE; pool_valid_3x3=0, out_wr_en=0, out_data=0, busy=0, result_count=0, internal accumulator/index/NaN flag cleared. Reset overrides everything, including mid-operation; no FIFO write from an aborted window.
- All outputs are registered. busy=1 in CMP, WRITE and DONE.
- Ordering key: key(x) = x[15] ? ~x : x ^ 16'h8000. Elements compare as unsigned keys. Consequences: -0 < +0; -inf is the minimum; +inf is the maximum non-NaN value.
- NaN: exp==5'h1F with mant!=0. If any element is NaN, the result is canonical qNaN 16'h7E00.
- Ties (equal keys): keep the accumulator; the bit pattern is identical either way.
- States: IDLE, CMP, WRITE, DONE.
- IDLE:
  - On an edge with pool_ready_3x3=1: capture im_3x3 into a local 144-bit buffer.
  - acc <= elem0; nan_flag <= isnan(elem0); idx <= 1; go to CMP.
- CMP:
  - Each edge: if key(elem[idx]) > key(acc) then acc <= elem[idx]; nan_flag |= isnan(elem[idx]); idx++.
  - After idx==8 is processed, go to WRITE.
  - pool_ready_3x3 and im_3x3 are ignored; the buffer is used.
- WRITE:
  - If out_full=1: stall, no strobe.
  - Else: out_wr_en <= 1 for exactly one cycle; out_data <= nan_flag ? 16'h7E00 : acc; result_count++; pool_valid_3x3 <= 1; go to DONE.
- DONE:
  - out_wr_en <= 0.
  - If pool_ready_3x3=0: pool_valid_3x3 <= 0, go to IDLE.
  - Else hold valid.
  - A new window starts only from IDLE, so a level-held ready never starts a second operation.
- Latency (FIFO not full): ready sampled at edge E0 → compares at E1..E8 → out_wr_en and pool_valid_3x3 rise after E9. Total 9 cycles ready-to-strobe.
- Throughput: one window per 11 cycles minimum (E0..E9 plus the DONE→IDLE handshake).
- If ready deasserts mid-CMP: the operation still completes and writes. valid is then high for exactly one cycle (DONE sees ready low).
- out_full toggling during WRITE: the strobe is issued on the first edge where out_full=0. No data loss, no duplicate write.
- result_count wraps 16'hFFFF → 0.

Decomposition:
- Shared package pool_pkg:
  - DW and NUM_ELEM constants.
  - FP16_QNAN = 16'h7E00.
  - State encoding: IDLE=2'd0, CMP=2'd1, WRITE=2'd2, DONE=2'd3.
  - Functions fp16_key and fp16_isnan.
- One natural sub-module: fp16_max2. It is combinational: inputs a, b; outputs max and any_nan. It is reused later by the 13x13 pooling path.

Test Plan:
- Window {0x3C00,0x4000,0xBC00,0xC000,0x3800,0x0000,0x8000,0x3E00,0x3A00}, out_full=0, ready held until valid → out_wr_en one pulse 9 cycles after ready sampled, out_data=0x4000, result_count=1; drop ready → valid clears next edge.
- All negative {0xC000,0xBC00,0xC400,…(all 0xC400)} → out_data=0xBC00. All {0x8000 except elem4=0x0000} → out_data=0x0000.
- Elem7=0x7E01 (NaN), others include 0x7C00 → out_data=0x7E00. Elems all 0xFC00 except elem8=0x7C00 → out_data=0x7C00.
- out_full=1 for 5 cycles at WRITE entry → no strobe while full; exactly one out_wr_en on the first not-full edge; pool_valid_3x3 rises with it.
- Ready held high continuously across two windows → only one write until ready drops; ready pulse of 1 cycle → full operation, valid high 1 cycle.
- rst asserted at CMP idx=4 → all outputs 0 next cycle, no out_wr_en, result_count unchanged (0); next window behaves normally.
